// File: rtl/reg_bus_master_if.sv
// rtl/reg_bus_master_if.sv - command, response and register-bus signals of reg_bus_master
interface reg_bus_master_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic [DATA_W-1:0] cmd_mask;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              busy;
   logic              req;
   logic              wr_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, rd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, req, wr_en, addr, wr_data
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, rd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, req, wr_en, addr, wr_data
   );
endinterface

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - single-outstanding write/read/poll initiator for the register bus
module reg_bus_master #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int POLL_GAP = 4,
   parameter int POLL_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   reg_bus_master_if.master  bus
);
   localparam int CNT_W = $clog2(POLL_MAX + 1);
   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_POLL  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_mask;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;
   logic [CNT_W-1:0]  r_cnt;
   logic [GAP_W-1:0]  r_gap;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_match;
   logic              w_accept;

   // Saturating count of reads issued by the current command.
   assign w_cnt_inc = (r_cnt == CNT_W'(POLL_MAX)) ? r_cnt : r_cnt + 1'b1;
   assign w_match   = ((bus.rd_data & r_mask) == (r_data & r_mask));
   assign w_accept  = (r_state == S_IDLE) && bus.cmd_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      bus.cmd_ready = 1'b0;
      bus.busy      = 1'b1;
      bus.req       = 1'b0;
      bus.wr_en     = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.addr      = r_addr;
      bus.wr_data   = r_data;
      bus.rsp_data  = r_rsp_data;
      bus.rsp_err   = r_rsp_err;
      case (r_state)
         S_IDLE: begin
            bus.cmd_ready = 1'b1;
            bus.busy      = 1'b0;
            if (bus.cmd_valid) w_next = (bus.cmd_op == OP_RSVD) ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            bus.req   = 1'b1;
            bus.wr_en = (r_op == OP_WRITE);
            if (r_op == OP_POLL && !w_match && w_cnt_inc != CNT_W'(POLL_MAX)) w_next = S_WAIT;
            else                                                              w_next = S_RESP;
         end
         S_WAIT: begin
            if (r_gap == GAP_W'(POLL_GAP - 1)) w_next = S_ACCESS;
         end
         S_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op       <= 2'b00;
         r_addr     <= '0;
         r_data     <= '0;
         r_mask     <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         r_cnt      <= '0;
         r_gap      <= '0;
      end else begin
         if (w_accept) begin
            r_op   <= bus.cmd_op;
            r_addr <= bus.cmd_addr;
            r_data <= bus.cmd_data;
            r_mask <= bus.cmd_mask;
            r_cnt  <= '0;
            if (bus.cmd_op == OP_RSVD) begin
               r_rsp_data <= '0;
               r_rsp_err  <= 1'b1;
            end
         end
         if (r_state == S_ACCESS) begin
            // A poll that reaches RESP without a match is by construction a timeout.
            r_cnt      <= w_cnt_inc;
            r_gap      <= '0;
            r_rsp_data <= (r_op == OP_WRITE) ? '0 : bus.rd_data;
            r_rsp_err  <= (r_op == OP_POLL) && !w_match;
         end
         if (r_state == S_WAIT) r_gap <= r_gap + 1'b1;
      end
   end
endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - scoreboard bench for reg_bus_master against a small register block
module tb_reg_bus_master;
   localparam int AW = 8, DW = 8, GAP = 4, PMAX = 16;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         lat;
      int         reqs;
      int         wrs;
      int         gap;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   reg_bus_master #(.ADDR_W(AW), .DATA_W(DW), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Register block: addr 4 decimation (reset 0x01), addr 5 read-only chip ID 0xA5.
   logic [7:0] regs [0:7];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) regs[i] <= (i == 4) ? 8'h01 : ((i == 5) ? 8'hA5 : 8'h00);
      end else if (bus.req && bus.wr_en && bus.addr < 8'd8 && bus.addr != 8'd5) begin
         regs[bus.addr[2:0]] <= bus.wr_data;
      end
   end
   assign bus.rd_data = (bus.addr < 8'd8) ? regs[bus.addr[2:0]] : 8'h00;

   int   n_assert = 0;
   int   n_fail = 0;
   int   n_done = 0;
   int   cyc = 0;
   exp_t sb_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: tracks accept, bus pulses and responses; pops the scoreboard on each new response.
   int         acc_cyc, req_cnt, wr_cnt, last_req, gap_min, gap_max;
   logic       rsp_seen = 1'b0;
   logic [7:0] held_data;
   logic       held_err;
   exp_t       e;
   always @(negedge clk) begin
      if (!rst_n) begin
         rsp_seen = 1'b0;
         req_cnt  = 0;
         wr_cnt   = 0;
      end else begin
         if (bus.cmd_valid && bus.cmd_ready) begin
            acc_cyc = cyc;
            req_cnt = 0;
            wr_cnt  = 0;
            gap_min = 1000000;
            gap_max = 0;
         end
         if (bus.req) begin
            if (req_cnt > 0) begin
               if (cyc - last_req < gap_min) gap_min = cyc - last_req;
               if (cyc - last_req > gap_max) gap_max = cyc - last_req;
            end
            last_req = cyc;
            req_cnt++;
            if (bus.wr_en) wr_cnt++;
         end
         if (bus.wr_en && !bus.req) check("wr_en_without_req", 32'(bus.wr_en), 32'd0);
         if (bus.rsp_valid) begin
            if (!rsp_seen) begin
               rsp_seen  = 1'b1;
               held_data = bus.rsp_data;
               held_err  = bus.rsp_err;
               if (sb_q.size() == 0) begin
                  check("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                  check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                  check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                  check("req_count", 32'(req_cnt), 32'(e.reqs));
                  check("wr_count", 32'(wr_cnt), 32'(e.wrs));
                  if (e.gap > 0) begin
                     check("req_gap_min", 32'(gap_min), 32'(e.gap));
                     check("req_gap_max", 32'(gap_max), 32'(e.gap));
                  end
               end
            end else begin
               check("rsp_data_stable", 32'(bus.rsp_data), 32'(held_data));
               check("rsp_err_stable", 32'(bus.rsp_err), 32'(held_err));
            end
            if (bus.rsp_ready) begin
               rsp_seen = 1'b0;
               n_done++;
            end
         end
      end
   end

   task automatic expect_rsp(input logic [7:0] d, input logic er, input int lat, input int reqs,
                             input int wrs, input int gap);
      exp_t x;
      x.data = d; x.err = er; x.lat = lat; x.reqs = reqs; x.wrs = wrs; x.gap = gap;
      sb_q.push_back(x);
   endtask

   task automatic wait_accept();
      int b = 0;
      @(negedge clk);
      while (!bus.cmd_ready && b < 300) begin
         @(negedge clk);
         b++;
      end
      if (!bus.cmd_ready) check("accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic drive_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] m);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = a;
      bus.cmd_data  = d;
      bus.cmd_mask  = m;
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] m);
      @(posedge clk);
      #1 drive_cmd(op, a, d, m);
      wait_accept();
   endtask

   task automatic wait_done(input int target);
      int b = 0;
      while (n_done < target && b < 300) begin
         @(negedge clk);
         b++;
      end
      check("rsp_done", 32'(n_done), 32'(target));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   int tgt = 0;
   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = 8'h00;
      bus.cmd_data  = 8'h00;
      bus.cmd_mask  = 8'h00;
      bus.rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req", 32'(bus.req), 32'd0);
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_addr", 32'(bus.addr), 32'd0);
      check("rst_wr_data", 32'(bus.wr_data), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      rst_n = 1'b1;

      expect_rsp(8'h00, 1'b0, 2, 1, 1, 0); issue(2'b00, 8'h00, 8'h7F, 8'h00); wait_done(++tgt);
      expect_rsp(8'h7F, 1'b0, 2, 1, 0, 0); issue(2'b01, 8'h00, 8'h00, 8'h00); wait_done(++tgt);
      expect_rsp(8'hA5, 1'b0, 2, 1, 0, 0); issue(2'b10, 8'h05, 8'hA5, 8'hFF); wait_done(++tgt);

      pulse_reset();
      expect_rsp(8'h00, 1'b1, 77, 16, 0, 5); issue(2'b10, 8'h00, 8'h55, 8'hFF); wait_done(++tgt);

      expect_rsp(8'h00, 1'b1, 1, 0, 0, 0); issue(2'b11, 8'h04, 8'h00, 8'h00); wait_done(++tgt);
      expect_rsp(8'h01, 1'b0, 2, 1, 0, 0); issue(2'b01, 8'h04, 8'h00, 8'h00); wait_done(++tgt);

      // Backpressure with a second command held on the port.
      bus.rsp_ready = 1'b0;
      expect_rsp(8'hA5, 1'b0, 2, 1, 0, 0); issue(2'b01, 8'h05, 8'h00, 8'h00);
      drive_cmd(2'b01, 8'h04, 8'h00, 8'h00);
      expect_rsp(8'h01, 1'b0, 2, 1, 0, 0);
      for (int b = 0; b < 20 && !bus.rsp_valid; b++) @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("bp_req", 32'(bus.req), 32'd0);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      ++tgt;
      wait_accept();
      check("accept_after_handshake", 32'(n_done), 32'(tgt));
      wait_done(++tgt);

      // Reset during the WAIT of a poll that would time out.
      issue(2'b10, 8'h06, 8'h55, 8'hFF);
      for (int b = 0; b < 20 && !bus.req; b++) @(negedge clk);
      check("poll_req_seen", 32'(bus.req), 32'd1);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_req", 32'(bus.req), 32'd0);
      check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("mid_rst_addr", 32'(bus.addr), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check("no_rsp_after_reset", 32'(n_done), 32'(tgt));
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
